// File: rtl/quantum_dispatcher.sv
// Round-robin process dispatcher: slot table, create/exit/preempt handling and one-probe-per-cycle search.
// Optional preemption statistics counter is built when DISPATCH_STATS_EN is defined.
module quantum_dispatcher #(
    parameter int unsigned NPROC     = 4,
    parameter int unsigned PROG_BASE = 616
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     preempt,
    input  logic [31:0]              pc_saved,
    input  logic                     proc_exit,
    input  logic                     dispatch_req,
    input  logic                     create_valid,
    input  logic [31:0]              create_pc,
    input  logic [31:0]              create_qtm,
    output logic                     create_ready,
    output logic                     create_err,
    output logic                     next_valid,
    output logic [31:0]              next_pc,
    output logic [31:0]              next_qtm,
    output logic [$clog2(NPROC)-1:0] next_id,
    output logic                     flagQtm,
    output logic                     none_ready,
    output logic                     busy,
    output logic [31:0]              preempt_count
);

    localparam int unsigned IW = $clog2(NPROC);

    typedef enum logic [1:0] {StIdle, StSearch, StDispatch} state_t;

    state_t          state_q, state_d;
    logic            slot_valid_q [NPROC];
    logic [31:0]     slot_pc_q    [NPROC];
    logic [31:0]     slot_qtm_q   [NPROC];
    logic [IW-1:0]   cur_id_q;
    logic            running_q;
    logic [IW-1:0]   probe_cnt_q;
    logic [31:0]     next_pc_q;
    logic [31:0]     next_qtm_q;
    logic [IW-1:0]   next_id_q;
    logic            create_err_q;
    logic            none_ready_q;

    logic            is_idle;
    logic            exit_acc;
    logic            pre_acc;
    logic            disp_acc;
    logic            create_fire;
    logic            create_ok;
    logic            has_free;
    logic [IW-1:0]   free_idx;
    logic [IW-1:0]   probe_idx;
    logic            probe_hit;
    logic            probe_last;

    // Event acceptance; exit and preempt only matter while a process is running.
    always_comb begin
        is_idle      = (state_q == StIdle);
        exit_acc     = is_idle && proc_exit && running_q;
        pre_acc      = is_idle && preempt && running_q && !exit_acc;
        disp_acc     = is_idle && dispatch_req && !running_q && !exit_acc && !pre_acc;
        create_ready = is_idle && !exit_acc && !pre_acc && !disp_acc;
        create_fire  = create_valid && create_ready;
    end

    // Lowest-index free slot: scan downwards so the smallest index wins.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IW'(i);
            end
        end
        create_ok = create_fire && has_free && (create_pc >= 32'(PROG_BASE));
    end

    // Index width equals log2(NPROC), so the sum wraps modulo NPROC for free.
    always_comb begin
        probe_idx  = cur_id_q + IW'(1) + probe_cnt_q;
        probe_hit  = slot_valid_q[probe_idx];
        probe_last = (probe_cnt_q == IW'(NPROC - 1));
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (exit_acc || pre_acc || disp_acc) begin
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (probe_hit) begin
                    state_d = StDispatch;
                end else if (probe_last) begin
                    state_d = StIdle;
                end
            end
            StDispatch: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_id_q     <= '0;
            running_q    <= 1'b0;
            probe_cnt_q  <= '0;
            next_pc_q    <= '0;
            next_qtm_q   <= '0;
            next_id_q    <= '0;
            create_err_q <= 1'b0;
            none_ready_q <= 1'b0;
            for (int i = 0; i < NPROC; i++) begin
                slot_valid_q[i] <= 1'b0;
                slot_pc_q[i]    <= '0;
                slot_qtm_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            create_err_q <= create_fire && !create_ok;
            none_ready_q <= (state_q == StSearch) && !probe_hit && probe_last;
            unique case (state_q)
                StIdle: begin
                    probe_cnt_q <= '0;
                    if (exit_acc) begin
                        slot_valid_q[cur_id_q] <= 1'b0;
                        running_q              <= 1'b0;
                    end else if (pre_acc) begin
                        slot_pc_q[cur_id_q] <= pc_saved;
                        running_q           <= 1'b0;
                    end
                    if (create_ok) begin
                        slot_valid_q[free_idx] <= 1'b1;
                        slot_pc_q[free_idx]    <= create_pc;
                        slot_qtm_q[free_idx]   <= create_qtm;
                    end
                end
                StSearch: begin
                    if (probe_hit) begin
                        cur_id_q   <= probe_idx;
                        running_q  <= 1'b1;
                        next_pc_q  <= slot_pc_q[probe_idx];
                        next_qtm_q <= slot_qtm_q[probe_idx];
                        next_id_q  <= probe_idx;
                    end else begin
                        probe_cnt_q <= probe_cnt_q + IW'(1);
                    end
                end
                StDispatch: probe_cnt_q <= '0;
                default:    probe_cnt_q <= '0;
            endcase
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] preempt_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            preempt_count_q <= '0;
        end else if (pre_acc) begin
            preempt_count_q <= preempt_count_q + 32'd1;
        end
    end

    assign preempt_count = preempt_count_q;
`else
    assign preempt_count = '0;
`endif

    assign next_valid = (state_q == StDispatch);
    assign flagQtm    = next_valid;
    assign next_pc    = next_pc_q;
    assign next_qtm   = next_qtm_q;
    assign next_id    = next_id_q;
    assign create_err = create_err_q;
    assign none_ready = none_ready_q;
    assign busy       = (state_q != StIdle);

endmodule
